// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage between EX and WB. Holds one instruction,
// waits for its load response, buffers responses that arrive while WB is
// stalled, aligns/extends load data, and discards responses that belong to
// loads killed by a flush.
module mem_stage_lsu #(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 32,
  parameter int REG_AW     = 5,
  parameter int MAX_CANCEL = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              es_to_ms_valid,
  output logic              ms_allowin,
  input  logic [PC_W-1:0]   es_pc,
  input  logic              es_gr_we,
  input  logic [REG_AW-1:0] es_dest,
  input  logic              es_is_load,
  input  logic [2:0]        es_ld_op,
  input  logic [DATA_W-1:0] es_alu_result,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  input  logic              flush,
  input  logic              ws_allowin,
  output logic              ms_to_ws_valid,
  output logic [PC_W-1:0]   ms_pc,
  output logic              ms_gr_we,
  output logic [REG_AW-1:0] ms_dest,
  output logic [DATA_W-1:0] ms_final_result,
  output logic              ms_fwd_we,
  output logic              ms_fwd_block,
  output logic [REG_AW-1:0] ms_fwd_dest,
  output logic [DATA_W-1:0] ms_fwd_value
);

  localparam int CNT_W = $clog2(MAX_CANCEL + 1);

  logic              ms_valid_q, ms_valid_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              gr_we_q, gr_we_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic              is_load_q, is_load_d;
  logic [2:0]        ld_op_q, ld_op_d;
  logic [1:0]        off_q, off_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic              data_buf_valid_q, data_buf_valid_d;
  logic [DATA_W-1:0] data_buf_q, data_buf_d;
  logic [CNT_W-1:0]  cancel_cnt_q, cancel_cnt_d;

  logic              cancel_idle;
  logic              ms_ready_go;
  logic              cancel_inc;
  logic              cancel_dec;
  logic              buf_capture;
  logic [DATA_W-1:0] word_sel;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] load_result;

  // A response only counts for the resident load once all stale ones are drained.
  assign cancel_idle    = (cancel_cnt_q == '0);
  assign ms_ready_go    = !is_load_q || data_buf_valid_q || (data_sram_data_ok && cancel_idle);
  assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go && !flush;
  assign ms_fwd_block   = ms_valid_q && is_load_q && !ms_ready_go;
  assign ms_fwd_we      = ms_valid_q && gr_we_q;
  assign ms_fwd_dest    = dest_q;
  assign ms_fwd_value   = ms_final_result;
  assign ms_pc          = pc_q;
  assign ms_gr_we       = gr_we_q;
  assign ms_dest        = dest_q;

  // Next-state for the pipeline register; flush kills whatever would be resident.
  always_comb begin
    ms_valid_d   = ms_valid_q;
    pc_d         = pc_q;
    gr_we_d      = gr_we_q;
    dest_d       = dest_q;
    is_load_d    = is_load_q;
    ld_op_d      = ld_op_q;
    off_d        = off_q;
    alu_result_d = alu_result_q;
    if (ms_allowin) ms_valid_d = es_to_ms_valid;
    if (flush)      ms_valid_d = 1'b0;
    if (es_to_ms_valid && ms_allowin) begin
      pc_d         = es_pc;
      gr_we_d      = es_gr_we;
      dest_d       = es_dest;
      is_load_d    = es_is_load;
      ld_op_d      = es_ld_op;
      off_d        = es_alu_result[1:0];
      alu_result_d = es_alu_result;
    end
  end

  // Hold a live response when WB cannot take it, so later rdata changes are harmless.
  always_comb begin
    buf_capture      = data_sram_data_ok && cancel_idle && ms_valid_q && is_load_q &&
                       !data_buf_valid_q && !ws_allowin;
    data_buf_valid_d = data_buf_valid_q;
    data_buf_d       = data_buf_q;
    if (flush || (ms_to_ws_valid && ws_allowin)) begin
      data_buf_valid_d = 1'b0;
    end else if (buf_capture) begin
      data_buf_valid_d = 1'b1;
      data_buf_d       = data_sram_rdata;
    end
  end

  // Count responses still owed to killed loads; they are swallowed as they arrive.
  always_comb begin
    cancel_inc   = flush && ms_fwd_block;
    cancel_dec   = data_sram_data_ok && !cancel_idle;
    cancel_cnt_d = cancel_cnt_q;
    if (cancel_inc && !cancel_dec) begin
      if (cancel_cnt_q != CNT_W'(MAX_CANCEL)) cancel_cnt_d = cancel_cnt_q + 1'b1;
    end else if (cancel_dec && !cancel_inc) begin
      cancel_cnt_d = cancel_cnt_q - 1'b1;
    end
  end

  // Select byte/half by the latched address offset and extend per load type.
  always_comb begin
    word_sel = data_buf_valid_q ? data_buf_q : data_sram_rdata;
    ld_byte  = word_sel[{off_q, 3'b000} +: 8];
    ld_half  = word_sel[{off_q[1], 4'b0000} +: 16];
    case (ld_op_q)
      3'd0:    load_result = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
      3'd1:    load_result = {{(DATA_W-8){1'b0}}, ld_byte};
      3'd2:    load_result = {{(DATA_W-16){ld_half[15]}}, ld_half};
      3'd3:    load_result = {{(DATA_W-16){1'b0}}, ld_half};
      default: load_result = word_sel;
    endcase
    ms_final_result = is_load_q ? load_result : alu_result_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q       <= 1'b0;
      pc_q             <= '0;
      gr_we_q          <= 1'b0;
      dest_q           <= '0;
      is_load_q        <= 1'b0;
      ld_op_q          <= '0;
      off_q            <= '0;
      alu_result_q     <= '0;
      data_buf_valid_q <= 1'b0;
      data_buf_q       <= '0;
      cancel_cnt_q     <= '0;
    end else begin
      ms_valid_q       <= ms_valid_d;
      pc_q             <= pc_d;
      gr_we_q          <= gr_we_d;
      dest_q           <= dest_d;
      is_load_q        <= is_load_d;
      ld_op_q          <= ld_op_d;
      off_q            <= off_d;
      alu_result_q     <= alu_result_d;
      data_buf_valid_q <= data_buf_valid_d;
      data_buf_q       <= data_buf_d;
      cancel_cnt_q     <= cancel_cnt_d;
    end
  end

endmodule
